// File: rtl/posit_accum_es3.sv
// posit_accum_es3 -- streaming posit<32,3> vector accumulator feeding a
// pipelined posit adder. Operands rotate over four partial-sum slots so the
// adder latency is hidden; a forwarded adder result lets a slot be reissued
// in the same cycle its previous sum returns. After the last operand the
// slots are folded pairwise (0+1, 2+3, then 0+2) and the sum is presented
// on a valid/ready output.
// Optional feature macro: POSIT_ACCUM_NAR_SHORTCUT_EN -- a NaR operand sets a
// sticky flag that suppresses further adds and forces a NaR result.
module posit_accum_es3 #(
  parameter int LATENCY = 4,
  parameter int NBITS   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  output logic             add_start,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_inf,
  input  logic             add_zero,
  input  logic             add_done
);

  localparam int NSLOT = 4;
  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_ACCUM, S_DRAIN, S_RED1, S_WAIT1, S_RED2, S_WAIT2, S_OUT
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] slot;
  } tag_t;

  state_t                        state_q, state_d;
  logic [NSLOT-1:0][NBITS-1:0]   slot_q, slot_d;
  logic [NSLOT-1:0]              busy_q, busy_d;
  logic [1:0]                    ptr_q, ptr_d;
  tag_t [LATENCY-1:0]            tag_q, tag_d;
  logic                          red_ph_q, red_ph_d;
  logic                          add_start_q, add_start_d;
  logic [NBITS-1:0]              add_in1_q, add_in1_d;
  logic [NBITS-1:0]              add_in2_q, add_in2_d;
  logic                          out_valid_q, out_valid_d;
  logic [NBITS-1:0]              out_data_q, out_data_d;
  logic                          out_inf_q, out_inf_d;
  logic                          out_zero_q, out_zero_d;

  tag_t             tag_out;
  logic             wb, fwd, accept, out_hs, tag_nxt_empty;
  logic             nar, op_nar, skip;
  logic             issue;
  logic [1:0]       iss_slot;
  logic [NBITS-1:0] op1, op2, res;

  // Adder status flags are implied by the returned posit itself.
  logic unused_flags;
  assign unused_flags = add_inf ^ add_zero;

  assign tag_out = tag_q[LATENCY-1];
  assign wb      = add_done & tag_out.vld;
  assign fwd     = wb & (tag_out.slot == ptr_q);
  assign in_ready = rst_n & (state_q == S_ACCUM) & (nar | ~busy_q[ptr_q] | fwd);
  assign accept  = in_valid & in_ready;
  assign out_hs  = out_valid_q & out_ready;

`ifdef POSIT_ACCUM_NAR_SHORTCUT_EN
  logic nar_q, nar_d;
  assign nar    = nar_q;
  assign op_nar = (in_data == NAR);

  // Sticky NaR: set by an accepted NaR operand, cleared when the result leaves.
  always_comb begin
    nar_d = nar_q;
    if (accept && op_nar) nar_d = 1'b1;
    if (out_hs)           nar_d = 1'b0;
  end

  // NaR flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nar_q <= 1'b0;
    else        nar_q <= nar_d;
  end
`else
  assign nar    = 1'b0;
  assign op_nar = 1'b0;
`endif

  assign skip = nar | op_nar;

  // Entries that will still be in flight next cycle (everything but the head).
  always_comb begin
    tag_nxt_empty = 1'b1;
    for (int i = 0; i < LATENCY-1; i++)
      if (tag_q[i].vld) tag_nxt_empty = 1'b0;
  end

  // Next-state: writeback first, then FSM-driven issue, then output capture.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    red_ph_d    = red_ph_q;
    tag_d       = {tag_q[LATENCY-2:0], tag_t'('0)};
    add_start_d = 1'b0;
    add_in1_d   = add_in1_q;
    add_in2_d   = add_in2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_inf_d   = out_inf_q;
    out_zero_d  = out_zero_q;
    issue       = 1'b0;
    iss_slot    = 2'd0;
    op1         = '0;
    op2         = '0;
    res         = '0;

    // A returning sum lands in its slot; a same-cycle reissue re-sets busy below.
    if (wb) begin
      slot_d[tag_out.slot] = add_result;
      busy_d[tag_out.slot] = 1'b0;
    end

    case (state_q)
      S_ACCUM: begin
        if (accept) begin
          if (in_last) state_d = S_DRAIN;
          if (!skip) begin
            issue    = 1'b1;
            iss_slot = ptr_q;
            op1      = in_data;
            op2      = fwd ? add_result : slot_q[ptr_q];
            ptr_d    = ptr_q + 2'd1;
          end
        end
      end
      S_DRAIN: begin
        red_ph_d = 1'b0;
        if ((busy_d == '0) && tag_nxt_empty) state_d = nar ? S_OUT : S_RED1;
      end
      S_RED1: begin
        issue = 1'b1;
        if (!red_ph_q) begin
          iss_slot = 2'd0;
          op1      = slot_q[0];
          op2      = slot_q[1];
          red_ph_d = 1'b1;
        end else begin
          iss_slot = 2'd2;
          op1      = slot_q[2];
          op2      = slot_q[3];
          red_ph_d = 1'b0;
          state_d  = S_WAIT1;
        end
      end
      S_WAIT1: if (busy_d == '0) state_d = S_RED2;
      S_RED2: begin
        issue    = 1'b1;
        iss_slot = 2'd0;
        op1      = slot_q[0];
        op2      = slot_q[2];
        state_d  = S_WAIT2;
      end
      S_WAIT2: if (busy_d == '0) state_d = S_OUT;
      S_OUT: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          slot_d      = '0;
          ptr_d       = 2'd0;
          state_d     = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase

    if (issue) begin
      busy_d[iss_slot] = 1'b1;
      tag_d[0]         = {1'b1, iss_slot};
      add_start_d      = 1'b1;
      add_in1_d        = op1;
      add_in2_d        = op2;
    end

    // Capture the result on entry to OUT; it then holds until consumed.
    if ((state_d == S_OUT) && (state_q != S_OUT)) begin
      res         = nar ? NAR : slot_d[0];
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_inf_d   = (res == NAR);
      out_zero_d  = (res == '0);
    end
  end

  // State registers; reset drops everything, including in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      slot_q      <= '0;
      busy_q      <= '0;
      ptr_q       <= 2'd0;
      tag_q       <= '0;
      red_ph_q    <= 1'b0;
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      tag_q       <= tag_d;
      red_ph_q    <= red_ph_d;
      add_start_q <= add_start_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_inf_q   <= out_inf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign add_start = add_start_q;
  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_inf   = out_inf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_posit_accum_es3.sv
// tb_posit_accum_es3 -- random and directed vectors for posit_accum_es3.
// Operands are small integers, so every posit<32,3> sum is exact; the
// reference result is the plain integer sum of the vector (NaR if any
// element is NaR), encoded as a posit. A behavioural adder answers each
// add_start with the posit sum, LATENCY cycles after the operand handshake.
module tb_posit_accum_es3;
  localparam int LAT = 4;
  localparam logic [31:0] NAR = 32'h8000_0000;
  localparam int NARV = 9999;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [31:0] out_data;
  logic        out_inf, out_zero, out_valid, out_ready = 1'b0;
  logic [31:0] add_in1, add_in2, add_result;
  logic        add_start, add_inf, add_zero, add_done;

  int tot = 0, bad = 0, cyc = 0, stalls = 0;

  posit_accum_es3 #(.LATENCY(LAT), .NBITS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_inf(out_inf), .out_zero(out_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // posit<32,3> -> real
  function automatic real p2r(input logic [31:0] p);
    logic [31:0] a;
    logic r0;
    int i, run, k, e, sc;
    real v, w;
    if (p == 32'd0) return 0.0;
    a = p[31] ? -p : p;
    r0 = a[30]; run = 0; i = 30;
    while (i >= 0 && a[i] == r0) begin run++; i--; end
    i--;
    k = r0 ? run - 1 : -run;
    e = 0;
    for (int j = 0; j < 3; j++) begin e = e * 2 + ((i >= 0) ? int'(a[i]) : 0); i--; end
    v = 1.0; w = 0.5;
    while (i >= 0) begin if (a[i]) v += w; w = w / 2.0; i--; end
    sc = 8 * k + e;
    for (int j = 0; j < sc; j++) v = v * 2.0;
    for (int j = 0; j > sc; j--) v = v / 2.0;
    return p[31] ? -v : v;
  endfunction

  // integer -> posit<32,3> (exact for |n| < 2^20)
  function automatic logic [31:0] i2p(input longint n);
    longint m;
    int s, k, e, pos;
    logic [31:0] b;
    if (n == 0) return 32'd0;
    m = (n < 0) ? -n : n;
    s = 0;
    while ((m >> (s + 1)) != 0) s++;
    k = s / 8; e = s % 8;
    b = '0; pos = 30;
    for (int j = 0; j <= k; j++) begin b[pos] = 1'b1; pos--; end
    pos--;
    for (int j = 2; j >= 0; j--) begin b[pos] = e[j]; pos--; end
    for (int j = s - 1; j >= 0; j--) begin if (pos >= 0) b[pos] = m[j]; pos--; end
    return (n < 0) ? -b : b;
  endfunction

  function automatic logic [31:0] enc(input int v);
    return (v == NARV) ? NAR : i2p(longint'(v));
  endfunction

  function automatic logic [31:0] padd(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    return i2p(longint'(p2r(a) + p2r(b)));
  endfunction

  // Reference: integer sum of the vector, NaR dominates.
  function automatic logic [31:0] ref_sum(input int v[$]);
    longint s = 0;
    foreach (v[i]) begin
      if (v[i] == NARV) return NAR;
      s += v[i];
    end
    return i2p(s);
  endfunction

  // Behavioural adder; it is not reset, so sums in flight across a reset still return.
  logic [LAT-2:0] pv = '0;
  logic [31:0]    pr [0:LAT-2];
  always @(posedge clk) begin
    pv    <= {pv[LAT-3:0], add_start};
    pr[0] <= padd(add_in1, add_in2);
    for (int i = 1; i < LAT - 1; i++) pr[i] <= pr[i-1];
  end
  assign add_done   = pv[LAT-2];
  assign add_result = pr[LAT-2];
  assign add_inf    = add_done & (add_result == NAR);
  assign add_zero   = add_done & (add_result == 32'd0);

`ifdef POSIT_ACCUM_NAR_SHORTCUT_EN
  bit nar_watch = 1'b0;
  int nar_starts = 0;
  always @(posedge clk) if (nar_watch && add_start) nar_starts <= nar_starts + 1;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offer one operand (called at a negedge); returns at the negedge after acceptance.
  task automatic put(input logic [31:0] d, input bit last, output int t_acc);
    int n;
    n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    stalls += n;
    if (!in_ready) chk("put_timeout", {31'd0, in_ready}, 32'd1);
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec(input int v[$], input int gap_max, output int t_last);
    int t;
    t = 0;
    foreach (v[i]) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      put(enc(v[i]), (i == v.size() - 1), t);
    end
    t_last = t;
  endtask

  task automatic wait_out(output int t);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("out_timeout", {31'd0, out_valid}, 32'd1);
    t = cyc;
  endtask

  // Wait for the result, stall it for 'hold' cycles, then consume it.
  task automatic get(input int hold, output logic [31:0] d, output logic inf,
                     output logic zero, output int t_v);
    wait_out(t_v);
    d = out_data; inf = out_inf; zero = out_zero;
    repeat (hold) begin
      @(negedge clk);
      chk("stall_hold", out_data, d);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int v[$], input int gap_max,
                         input int hold, input int exp_lat);
    logic [31:0] d, e;
    logic inf, zero;
    int tl, tv;
    e = ref_sum(v);
    send_vec(v, gap_max, tl);
    get(hold, d, inf, zero, tv);
    chk({tag, "_data"}, d, e);
    chk({tag, "_inf"},  {31'd0, inf},  {31'd0, e == NAR});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(tv - tl), 32'(exp_lat));
  endtask

  initial begin
    int v[$];
    int t, s0;
    logic [31:0] held, e;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_flags", {30'd0, out_inf, out_zero}, 32'd0);
    chk("rst_add_start", {31'd0, add_start}, 32'd0);
    chk("rst_add_in",    add_in1 | add_in2, 32'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // 4 x 1.0 back-to-back -> 4.0, output 16 cycles after the last handshake
    v = '{1, 1, 1, 1};
    chk("enc_4", ref_sum(v), 32'h4800_0000);
    run_vec("four", v, 0, 0, 16);

    // 8 x 1.0, no stalls allowed (forwarding) -> 8.0
    s0 = stalls;
    v = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_vec("eight", v, 0, 0, 16);
    chk("eight_stalls", 32'(stalls - s0), 32'd0);
    chk("eight_val", ref_sum(v), 32'h4C00_0000);

    // 1 + (-1) -> zero
    v = '{1, -1};
    run_vec("cancel", v, 0, 0, 16);

    // single element 2.0
    v = '{2};
    run_vec("single", v, 0, 0, 16);

    // output stalled 10 cycles with the next vector already offered
    v = '{3, -5, 7};
    e = ref_sum(v);
    send_vec(v, 3, t);
    wait_out(t);
    held = out_data;
    in_data = enc(5); in_last = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_data", out_data, held);
      chk("hold_block", {31'd0, in_ready}, 32'd0);
    end
    chk("hold_sum", held, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    v = '{5};
    run_vec("after_hold", v, 0, 0, 0);

    // NaR in the middle of a vector
    begin
      int ta;
      put(enc(1), 1'b0, ta);
      put(NAR, 1'b0, ta);
`ifdef POSIT_ACCUM_NAR_SHORTCUT_EN
      nar_watch = 1'b1;
`endif
      v = '{1};
      run_vec("nar", '{1, NARV, 1}, 0, 0, 0);
    end
`ifdef POSIT_ACCUM_NAR_SHORTCUT_EN
    nar_watch = 1'b0;
    chk("nar_no_start", 32'(nar_starts), 32'd0);
`endif

    // reset with adds in flight; stale results must not leak into the next vector
    begin
      int ta;
      put(enc(4), 1'b0, ta);
      put(enc(6), 1'b0, ta);
      put(enc(-3), 1'b0, ta);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready0", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1 chk("midrst_ready1", {31'd0, in_ready}, 32'd1);
      v = '{2, 3};
      run_vec("midrst", v, 0, 0, 0);
    end

    // random vectors, gaps and output stalls
    for (int n = 0; n < 25; n++) begin
      int len;
      v = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        v.push_back(($urandom_range(0, 29) == 0) ? NARV : int'($urandom_range(0, 16)) - 8);
      run_vec("rnd", v, 2, $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
